// File: rtl/spi_reg_controller.sv
// SPI register-file sequencer: command byte, then write data or read slots.
// Build option SPI_REG_CTRL_AUTOINC_EN: advance the address after each data byte.

module spi_reg_controller #(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter logic [7:0] OOR_BYTE = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_rxDataValid,
  input  logic [7:0]            i_rxData,
  output logic                  o_txDataValid,
  output logic [7:0]            o_txData,
  input  logic                  i_SPI_CS_n,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_wrStrobe,
  output logic [6:0]            o_wrAddr,
  output logic                  o_frameDone
);

  localparam int         AW   = $clog2(NUM_REGS);
  localparam logic [7:0] NREG = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WRITE, S_READ, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_cs1;
  logic       r_cs2;
  logic       r_csPrev;
  logic [1:0] r_settle;
  logic       r_armed;
  logic       w_csRise;
  logic       w_rx;

  logic [6:0] r_addr;
  logic [6:0] w_addrStep;
  logic [7:0] r_regs [NUM_REGS];

  logic       r_txValid;
  logic [7:0] r_txData;
  logic       r_wrStrobe;
  logic [6:0] r_wrAddr;
  logic       r_frameDone;

  logic       w_txLoad;
  logic [7:0] w_txByte;
  logic       w_wrEn;
  logic       w_addrLd;
  logic [6:0] w_addrNew;
  logic       w_frameDone;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NREG;
  endfunction

  function automatic logic [7:0] rd(input logic [6:0] a);
    if (in_range(a))
      return r_regs[a[AW-1:0]];
    return OOR_BYTE;
  endfunction

  assign w_csRise = r_cs2 & ~r_csPrev;
  assign w_rx     = i_rxDataValid & r_armed;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign w_addrStep = r_addr + 7'd1;
`else
  assign w_addrStep = r_addr;
`endif

  // After reset the syncs read 1 until real CS arrives; arm only
  // once CS is truly high, so a frame cut by reset is ignored.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cs1    <= 1'b1;
      r_cs2    <= 1'b1;
      r_csPrev <= 1'b1;
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_cs1    <= i_SPI_CS_n;
      r_cs2    <= r_cs1;
      r_csPrev <= r_cs2;
      r_settle <= {r_settle[0], 1'b1};
      if (w_csRise || (r_settle[1] && r_cs2))
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_CMD;
      S_CMD: begin
        if (w_csRise)
          w_next = S_DONE;
        else if (w_rx)
          w_next = i_rxData[7] ? S_READ : S_WRITE;
      end
      S_WRITE, S_READ: begin
        if (w_csRise)
          w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_txLoad    = 1'b0;
    w_txByte    = 8'h00;
    w_wrEn      = 1'b0;
    w_addrLd    = 1'b0;
    w_addrNew   = r_addr;
    w_frameDone = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_txLoad = 1'b1;
        w_txByte = HDR_BYTE;
      end
      S_CMD: begin
        if (w_rx) begin
          w_addrLd  = 1'b1;
          w_addrNew = i_rxData[6:0];
          if (i_rxData[7]) begin
            w_txLoad = 1'b1;
            w_txByte = rd(i_rxData[6:0]);
          end
        end
      end
      S_WRITE: begin
        if (w_rx) begin
          w_wrEn    = in_range(r_addr);
          w_addrLd  = 1'b1;
          w_addrNew = w_addrStep;
        end
      end
      S_READ: begin
        if (w_rx) begin
          w_addrLd  = 1'b1;
          w_addrNew = w_addrStep;
          w_txLoad  = 1'b1;
          w_txByte  = rd(w_addrStep);
        end
      end
      S_DONE: w_frameDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int n = 0; n < NUM_REGS; n++)
        r_regs[n] <= 8'h00;
      r_addr      <= 7'd0;
      r_txValid   <= 1'b0;
      r_txData    <= 8'h00;
      r_wrStrobe  <= 1'b0;
      r_wrAddr    <= 7'd0;
      r_frameDone <= 1'b0;
    end else begin
      r_txValid   <= w_txLoad;
      r_wrStrobe  <= w_wrEn;
      r_frameDone <= w_frameDone;
      if (w_txLoad)
        r_txData <= w_txByte;
      if (w_wrEn) begin
        r_wrAddr               <= r_addr;
        r_regs[r_addr[AW-1:0]] <= i_rxData;
      end
      if (w_addrLd)
        r_addr <= w_addrNew;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign o_regs[8*g +: 8] = r_regs[g];
  end

  assign o_txDataValid = r_txValid;
  assign o_txData      = r_txData;
  assign o_wrStrobe    = r_wrStrobe;
  assign o_wrAddr      = r_wrAddr;
  assign o_frameDone   = r_frameDone;

endmodule
